dpram_param: RTL and testbench



---
 rtl/dpram_pkg.sv | 25 ++
 rtl/dpram_rd_pipe.sv | 62 ++++++
 rtl/dpram_param.sv | 151 +++++++++++++++
 tb/tb_dpram_param.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : dpram_pkg
// Purpose  : Shared constants and helpers for the dpram_param dual-port RAM.
// Revision : 1.0 - initial release
// ============================================================================
package dpram_pkg;

    // Same-port read-during-write behaviour
    localparam int WRM_NO_CHANGE   = 0;
    localparam int WRM_READ_FIRST  = 1;
    localparam int WRM_WRITE_FIRST = 2;

    // Legal read latency range
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    // Even-parity bit: makes the total count of ones (data + parity) even
    function automatic logic parity_even(input logic [63:0] data);
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dpram_rd_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : dpram_rd_pipe
// Purpose  : Per-port read output pipeline (1 or 2 stages) with valid strobe;
//            output data holds its last value when no read completes.
// Revision : 1.0 - initial release
// ============================================================================
module dpram_rd_pipe #(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_issue,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_dvalid
);

    logic              w_last_valid;
    logic [DATA_W-1:0] w_last_data;

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              r_s1_valid;
            logic [DATA_W-1:0] r_s1_data;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s1_valid <= 1'b0;
                    r_s1_data  <= '0;
                end else begin
                    r_s1_valid <= i_issue;
                    if (i_issue) begin
                        r_s1_data <= i_data;
                    end
                end
            end

            assign w_last_valid = r_s1_valid;
            assign w_last_data  = r_s1_data;
        end else begin : g_lat1
            assign w_last_valid = i_issue;
            assign w_last_data  = i_data;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_dvalid <= 1'b0;
            o_dout   <= '0;
        end else begin
            o_dvalid <= w_last_valid;
            if (w_last_valid) begin
                o_dout <= w_last_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dpram_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : dpram_param
// Purpose  : True dual-port synchronous RAM with per-port enables, selectable
//            read-during-write mode, 1/2-cycle read latency, collision flags.
// Options  : DPRAM_PARITY_EN adds a stored even-parity bit and a_perr/b_perr.
// Revision : 1.0 - initial release
// ============================================================================
module dpram_param
    import dpram_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 6,
    parameter int RD_LAT  = 1,
    parameter int WR_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    output logic [DATA_W-1:0] a_dout,
    output logic              a_dvalid,
    input  logic              b_en,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_din,
    output logic [DATA_W-1:0] b_dout,
    output logic              b_dvalid,
    output logic              coll_ww,
    output logic              coll_rw
`ifdef DPRAM_PARITY_EN
    ,
    output logic              a_perr,
    output logic              b_perr
`endif
);

    localparam int c_DEPTH = 2 ** ADDR_W;
`ifdef DPRAM_PARITY_EN
    localparam int c_MEM_W = DATA_W + 1;
`else
    localparam int c_MEM_W = DATA_W;
`endif

    generate
        if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
            $error("dpram_param: RD_LAT must be 1 or 2");
        end
        if (WR_MODE < WRM_NO_CHANGE || WR_MODE > WRM_WRITE_FIRST) begin : g_bad_wr_mode
            $error("dpram_param: WR_MODE must be 0, 1 or 2");
        end
        if (DATA_W < 1 || DATA_W > 64) begin : g_bad_data_w
            $error("dpram_param: DATA_W must be within 1..64");
        end
    endgenerate

    logic [c_MEM_W-1:0] r_mem [c_DEPTH];

    logic               w_a_wr, w_b_wr;
    logic               w_a_issue, w_b_issue;
    logic               w_a_bypass, w_b_bypass;
    logic               w_same_addr;
    logic [c_MEM_W-1:0] w_a_word, w_b_word;
    logic [c_MEM_W-1:0] w_a_wword, w_b_wword;
    logic [DATA_W-1:0]  w_a_rdata, w_b_rdata;
    logic [c_MEM_W-1:0] w_a_pin, w_b_pin, w_a_pout, w_b_pout;

    assign w_a_wr      = a_en & a_we;
    assign w_b_wr      = b_en & b_we;
    assign w_a_issue   = a_en & (~a_we | (WR_MODE != WRM_NO_CHANGE));
    assign w_b_issue   = b_en & (~b_we | (WR_MODE != WRM_NO_CHANGE));
    assign w_a_bypass  = a_we & (WR_MODE == WRM_WRITE_FIRST);
    assign w_b_bypass  = b_we & (WR_MODE == WRM_WRITE_FIRST);
    assign w_same_addr = (a_addr == b_addr);

    // Array read is taken before this edge's writes land: old contents
    assign w_a_word  = r_mem[a_addr];
    assign w_b_word  = r_mem[b_addr];
    assign w_a_rdata = w_a_bypass ? a_din : w_a_word[DATA_W-1:0];
    assign w_b_rdata = w_b_bypass ? b_din : w_b_word[DATA_W-1:0];

`ifdef DPRAM_PARITY_EN
    assign w_a_wword = {parity_even(64'(a_din)), a_din};
    assign w_b_wword = {parity_even(64'(b_din)), b_din};
    // Error flag rides the pipeline alongside the data word
    assign w_a_pin   = {~w_a_bypass & (parity_even(64'(w_a_word[DATA_W-1:0])) != w_a_word[DATA_W]),
                        w_a_rdata};
    assign w_b_pin   = {~w_b_bypass & (parity_even(64'(w_b_word[DATA_W-1:0])) != w_b_word[DATA_W]),
                        w_b_rdata};
    assign a_dout    = w_a_pout[DATA_W-1:0];
    assign b_dout    = w_b_pout[DATA_W-1:0];
    assign a_perr    = w_a_pout[DATA_W] & a_dvalid;
    assign b_perr    = w_b_pout[DATA_W] & b_dvalid;
`else
    assign w_a_wword = a_din;
    assign w_b_wword = b_din;
    assign w_a_pin   = w_a_rdata;
    assign w_b_pin   = w_b_rdata;
    assign a_dout    = w_a_pout;
    assign b_dout    = w_b_pout;
`endif

    // Port A is written last so it wins a same-address write/write clash
    always_ff @(posedge clk) begin
        if (w_b_wr) begin
            r_mem[b_addr] <= w_b_wword;
        end
        if (w_a_wr) begin
            r_mem[a_addr] <= w_a_wword;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_ww <= 1'b0;
            coll_rw <= 1'b0;
        end else begin
            coll_ww <= a_en & b_en & w_same_addr & a_we & b_we;
            coll_rw <= a_en & b_en & w_same_addr & (a_we ^ b_we);
        end
    end

    dpram_rd_pipe #(
        .DATA_W (c_MEM_W),
        .RD_LAT (RD_LAT)
    ) u_pipe_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_issue  (w_a_issue),
        .i_data   (w_a_pin),
        .o_dout   (w_a_pout),
        .o_dvalid (a_dvalid)
    );

    dpram_rd_pipe #(
        .DATA_W (c_MEM_W),
        .RD_LAT (RD_LAT)
    ) u_pipe_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_issue  (w_b_issue),
        .i_data   (w_b_pin),
        .o_dout   (w_b_pout),
        .o_dvalid (b_dvalid)
    );

endmodule
`default_nettype wire

// File: tb/tb_dpram_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dpram_param
// Purpose  : Directed bench for dpram_param: three configurations
//            (RD_LAT=1/NO_CHANGE, RD_LAT=2/READ_FIRST, RD_LAT=1/WRITE_FIRST).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpram_param;

    typedef struct packed {
        logic       a_en;
        logic       a_we;
        logic [5:0] a_addr;
        logic [7:0] a_din;
        logic       b_en;
        logic       b_we;
        logic [5:0] b_addr;
        logic [7:0] b_din;
    } stim_t;

    typedef struct packed {
        logic [7:0] a_dout;
        logic       a_dvalid;
        logic [7:0] b_dout;
        logic       b_dvalid;
        logic       coll_ww;
        logic       coll_rw;
    } resp_t;

    typedef struct packed {
        stim_t s;
        resp_t e;
    } vec_t;

    localparam int N_VEC = 15;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    stim_t s0    = '0;
    stim_t s1    = '0;
    stim_t s2    = '0;
    int    n_pass  = 0;
    int    n_total = 0;

    logic [7:0] d0_a_dout, d0_b_dout, d1_a_dout, d1_b_dout, d2_a_dout, d2_b_dout;
    logic       d0_a_dv, d0_b_dv, d0_cww, d0_crw;
    logic       d1_a_dv, d1_b_dv, d1_cww, d1_crw;
    logic       d2_a_dv, d2_b_dv, d2_cww, d2_crw;
`ifdef DPRAM_PARITY_EN
    logic       d0_a_perr, d0_b_perr, d1_a_perr, d1_b_perr, d2_a_perr, d2_b_perr;
`endif

    always #5 clk = ~clk;

    dpram_param #(.DATA_W(8), .ADDR_W(6), .RD_LAT(1), .WR_MODE(0)) u_d0 (
        .clk(clk), .rst_n(rst_n),
        .a_en(s0.a_en), .a_we(s0.a_we), .a_addr(s0.a_addr), .a_din(s0.a_din),
        .a_dout(d0_a_dout), .a_dvalid(d0_a_dv),
        .b_en(s0.b_en), .b_we(s0.b_we), .b_addr(s0.b_addr), .b_din(s0.b_din),
        .b_dout(d0_b_dout), .b_dvalid(d0_b_dv),
        .coll_ww(d0_cww), .coll_rw(d0_crw)
`ifdef DPRAM_PARITY_EN
        , .a_perr(d0_a_perr), .b_perr(d0_b_perr)
`endif
    );

    dpram_param #(.DATA_W(8), .ADDR_W(6), .RD_LAT(2), .WR_MODE(1)) u_d1 (
        .clk(clk), .rst_n(rst_n),
        .a_en(s1.a_en), .a_we(s1.a_we), .a_addr(s1.a_addr), .a_din(s1.a_din),
        .a_dout(d1_a_dout), .a_dvalid(d1_a_dv),
        .b_en(s1.b_en), .b_we(s1.b_we), .b_addr(s1.b_addr), .b_din(s1.b_din),
        .b_dout(d1_b_dout), .b_dvalid(d1_b_dv),
        .coll_ww(d1_cww), .coll_rw(d1_crw)
`ifdef DPRAM_PARITY_EN
        , .a_perr(d1_a_perr), .b_perr(d1_b_perr)
`endif
    );

    dpram_param #(.DATA_W(8), .ADDR_W(6), .RD_LAT(1), .WR_MODE(2)) u_d2 (
        .clk(clk), .rst_n(rst_n),
        .a_en(s2.a_en), .a_we(s2.a_we), .a_addr(s2.a_addr), .a_din(s2.a_din),
        .a_dout(d2_a_dout), .a_dvalid(d2_a_dv),
        .b_en(s2.b_en), .b_we(s2.b_we), .b_addr(s2.b_addr), .b_din(s2.b_din),
        .b_dout(d2_b_dout), .b_dvalid(d2_b_dv),
        .coll_ww(d2_cww), .coll_rw(d2_crw)
`ifdef DPRAM_PARITY_EN
        , .a_perr(d2_a_perr), .b_perr(d2_b_perr)
`endif
    );

    function automatic resp_t resp0();
        return {d0_a_dout, d0_a_dv, d0_b_dout, d0_b_dv, d0_cww, d0_crw};
    endfunction

    function automatic resp_t resp1();
        return {d1_a_dout, d1_a_dv, d1_b_dout, d1_b_dv, d1_cww, d1_crw};
    endfunction

    function automatic resp_t resp2();
        return {d2_a_dout, d2_a_dv, d2_b_dout, d2_b_dv, d2_cww, d2_crw};
    endfunction

    function automatic vec_t mk(
        input logic ae, input logic aw, input logic [5:0] aa, input logic [7:0] ad,
        input logic be, input logic bw, input logic [5:0] ba, input logic [7:0] bd,
        input logic [7:0] ea, input logic eav, input logic [7:0] eb, input logic ebv,
        input logic ww, input logic rw);
        vec_t v;
        v.s = {ae, aw, aa, ad, be, bw, ba, bd};
        v.e = {ea, eav, eb, ebv, ww, rw};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d done", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [N_VEC];
        // DUT0: RD_LAT=1, NO_CHANGE; expectations are outputs after the edge
        vecs[0]  = mk(1'b1,1'b1,6'd3, 8'h5A, 1'b0,1'b0,6'd0, 8'h00, 8'h00,1'b0, 8'h00,1'b0, 1'b0,1'b0);
        vecs[1]  = mk(1'b0,1'b0,6'd0, 8'h00, 1'b1,1'b0,6'd3, 8'h00, 8'h00,1'b0, 8'h5A,1'b1, 1'b0,1'b0);
        vecs[2]  = mk(1'b0,1'b0,6'd0, 8'h00, 1'b0,1'b0,6'd0, 8'h00, 8'h00,1'b0, 8'h5A,1'b0, 1'b0,1'b0);
        vecs[3]  = mk(1'b0,1'b0,6'd0, 8'h00, 1'b1,1'b1,6'd0, 8'h7E, 8'h00,1'b0, 8'h5A,1'b0, 1'b0,1'b0);
        vecs[4]  = mk(1'b1,1'b1,6'd63,8'hAA, 1'b1,1'b1,6'd63,8'h55, 8'h00,1'b0, 8'h5A,1'b0, 1'b1,1'b0);
        vecs[5]  = mk(1'b1,1'b0,6'd63,8'h00, 1'b1,1'b0,6'd63,8'h00, 8'hAA,1'b1, 8'hAA,1'b1, 1'b0,1'b0);
        vecs[6]  = mk(1'b1,1'b1,6'd5, 8'h01, 1'b0,1'b0,6'd0, 8'h00, 8'hAA,1'b0, 8'hAA,1'b0, 1'b0,1'b0);
        vecs[7]  = mk(1'b1,1'b1,6'd5, 8'h02, 1'b1,1'b0,6'd5, 8'h00, 8'hAA,1'b0, 8'h01,1'b1, 1'b0,1'b1);
        vecs[8]  = mk(1'b0,1'b0,6'd0, 8'h00, 1'b1,1'b0,6'd5, 8'h00, 8'hAA,1'b0, 8'h02,1'b1, 1'b0,1'b0);
        vecs[9]  = mk(1'b1,1'b0,6'd0, 8'h00, 1'b0,1'b0,6'd0, 8'h00, 8'h7E,1'b1, 8'h02,1'b0, 1'b0,1'b0);
        vecs[10] = mk(1'b1,1'b0,6'd3, 8'h00, 1'b0,1'b1,6'd3, 8'hFF, 8'h5A,1'b1, 8'h02,1'b0, 1'b0,1'b0);
        vecs[11] = mk(1'b1,1'b1,6'd7, 8'h33, 1'b0,1'b1,6'd7, 8'h44, 8'h5A,1'b0, 8'h02,1'b0, 1'b0,1'b0);
        vecs[12] = mk(1'b1,1'b0,6'd7, 8'h00, 1'b1,1'b0,6'd7, 8'h00, 8'h33,1'b1, 8'h33,1'b1, 1'b0,1'b0);
        vecs[13] = mk(1'b1,1'b0,6'd3, 8'h00, 1'b1,1'b1,6'd3, 8'h99, 8'h5A,1'b1, 8'h33,1'b0, 1'b0,1'b1);
        vecs[14] = mk(1'b1,1'b0,6'd3, 8'h00, 1'b1,1'b0,6'd3, 8'h00, 8'h99,1'b1, 8'h99,1'b1, 1'b0,1'b0);

        tick();
        tick();
        check("reset_d0", 32'(resp0()), 32'h0);
        check("reset_d1", 32'(resp1()), 32'h0);
        check("reset_d2", 32'(resp2()), 32'h0);
`ifdef DPRAM_PARITY_EN
        check("reset_perr", 32'({d0_a_perr, d0_b_perr, d1_a_perr, d1_b_perr, d2_a_perr, d2_b_perr}),
              32'h0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < N_VEC; i++) begin
            s0 = vecs[i].s;
            tick();
            check($sformatf("d0_vec%0d", i), 32'(resp0()), 32'(vecs[i].e));
        end
        s0 = '0;

        // WRITE_FIRST: write data bypasses to the same port's output
        s2.b_en = 1'b1; s2.b_we = 1'b1; s2.b_addr = 6'd0; s2.b_din = 8'h7E;
        tick();
        check("wf_bypass", 32'({d2_b_dout, d2_b_dv}), 32'({8'h7E, 1'b1}));
        s2.b_we = 1'b0; s2.b_din = 8'h00;
        tick();
        check("wf_readback", 32'({d2_b_dout, d2_b_dv}), 32'({8'h7E, 1'b1}));
        s2 = '0;
        tick();
        check("wf_hold", 32'({d2_b_dout, d2_b_dv}), 32'({8'h7E, 1'b0}));

        // READ_FIRST with RD_LAT=2: preload, overwrite, then read back-to-back
        s1.a_en = 1'b1; s1.a_we = 1'b1; s1.a_addr = 6'd10; s1.a_din = 8'h11;
        tick();
        s1 = '0;
        tick();
        s1.a_en = 1'b1; s1.a_we = 1'b1; s1.a_addr = 6'd10; s1.a_din = 8'h22;
        tick();
        check("rf_not_early", 32'(d1_a_dv), 32'h0);
        s1.a_we = 1'b0; s1.a_din = 8'h00;
        tick();
        check("rf_old_data", 32'({d1_a_dout, d1_a_dv}), 32'({8'h11, 1'b1}));
        s1 = '0;
        tick();
        check("rf_new_data", 32'({d1_a_dout, d1_a_dv}), 32'({8'h22, 1'b1}));
        tick();
        check("rf_hold", 32'({d1_a_dout, d1_a_dv}), 32'({8'h22, 1'b0}));

        // Reset while a RD_LAT=2 read is in flight
        s1.a_en = 1'b1; s1.a_addr = 6'd10;
        tick();
        s1 = '0;
        rst_n = 1'b0;
        #1;
        check("rst_async_clear", 32'({d1_a_dout, d1_a_dv}), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_no_stale_1", 32'(d1_a_dv), 32'h0);
        tick();
        check("rst_no_stale_2", 32'(d1_a_dv), 32'h0);
        s1.a_en = 1'b1; s1.a_addr = 6'd10;
        tick();
        s1 = '0;
        check("rst_lat2_pending", 32'(d1_a_dv), 32'h0);
        tick();
        check("rst_mem_kept", 32'({d1_a_dout, d1_a_dv}), 32'({8'h22, 1'b1}));

`ifdef DPRAM_PARITY_EN
        // Corrupt one stored data bit of addr 3; addr 5 stays intact
        u_d0.r_mem[3][0] = ~u_d0.r_mem[3][0];
        s0.a_en = 1'b1; s0.a_addr = 6'd3; s0.b_en = 1'b1; s0.b_addr = 6'd5;
        tick();
        s0 = '0;
        check("perr_a_flagged", 32'({d0_a_perr, d0_a_dv}), 32'h3);
        check("perr_b_clean", 32'({d0_b_perr, d0_b_dv, d0_b_dout}), 32'({1'b0, 1'b1, 8'h02}));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
